// File: rtl/alu_issue.sv
// alu_issue: RV32I decode/issue register feeding the ALU behind a valid/ready handshake.
// Optional ALU_ISSUE_SKID_EN adds a second (skid) entry and makes in_ready registered.
module alu_issue #(
   parameter int XLEN    = 32,
   parameter int PC_STEP = 4
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] alu_src0,
   output logic [XLEN-1:0] alu_src1,
   output logic [4:0]      alu_op,
   output logic [4:0]      out_rd,
   output logic            out_we,
   output logic            out_illegal
);

   localparam logic [4:0] OP_ADD  = 5'h00;
   localparam logic [4:0] OP_SUB  = 5'h02;
   localparam logic [4:0] OP_SLT  = 5'h04;
   localparam logic [4:0] OP_SLTU = 5'h05;
   localparam logic [4:0] OP_AND  = 5'h09;
   localparam logic [4:0] OP_OR   = 5'h0A;
   localparam logic [4:0] OP_XOR  = 5'h0B;
   localparam logic [4:0] OP_SLL  = 5'h0E;
   localparam logic [4:0] OP_SRL  = 5'h0F;
   localparam logic [4:0] OP_SRA  = 5'h10;
   localparam logic [4:0] OP_SRC1 = 5'h12;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef struct packed {
      logic [XLEN-1:0] src0;
      logic [XLEN-1:0] src1;
      logic [4:0]      op;
      logic [4:0]      rd;
      logic            we;
      logic            illegal;
   } entry_t;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic            alt;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_s;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] shamt;
   logic [4:0]      f3_op;
   entry_t          dec;

   assign opcode = in_inst[6:0];
   assign funct3 = in_inst[14:12];
   assign alt    = in_inst[30];
   assign imm_i  = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
   assign imm_s  = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
   assign imm_u  = {in_inst[31:12], 12'b0};
   assign shamt  = {{(XLEN-5){1'b0}}, in_inst[24:20]};

   // inst[30] means SUB only for register-register ops; ADDI ignores it.
   always_comb begin
      f3_op = OP_ADD;
      case (funct3)
         3'd0: f3_op = (alt && (opcode == OPC_R)) ? OP_SUB : OP_ADD;
         3'd1: f3_op = OP_SLL;
         3'd2: f3_op = OP_SLT;
         3'd3: f3_op = OP_SLTU;
         3'd4: f3_op = OP_XOR;
         3'd5: f3_op = alt ? OP_SRA : OP_SRL;
         3'd6: f3_op = OP_OR;
         default: f3_op = OP_AND;
      endcase
   end

   always_comb begin
      dec    = '0;
      dec.rd = in_inst[11:7];
      case (opcode)
         OPC_R: begin
            dec.src0 = in_rs1;
            dec.src1 = in_rs2;
            dec.op   = f3_op;
            dec.we   = 1'b1;
         end
         OPC_I: begin
            dec.src0 = in_rs1;
            dec.src1 = ((funct3 == 3'd1) || (funct3 == 3'd5)) ? shamt : imm_i;
            dec.op   = f3_op;
            dec.we   = 1'b1;
         end
         OPC_LUI: begin
            dec.src1 = imm_u;
            dec.op   = OP_SRC1;
            dec.we   = 1'b1;
         end
         OPC_AUIPC: begin
            dec.src0 = in_pc;
            dec.src1 = imm_u;
            dec.op   = OP_ADD;
            dec.we   = 1'b1;
         end
         OPC_JAL, OPC_JALR: begin
            dec.src0 = in_pc;
            dec.src1 = XLEN'(PC_STEP);
            dec.op   = OP_ADD;
            dec.we   = 1'b1;
         end
         OPC_LOAD: begin
            dec.src0 = in_rs1;
            dec.src1 = imm_i;
            dec.op   = OP_ADD;
            dec.we   = 1'b1;
         end
         OPC_STORE: begin
            dec.src0 = in_rs1;
            dec.src1 = imm_s;
            dec.op   = OP_ADD;
         end
         OPC_BRANCH: begin
            dec.src0 = in_rs1;
            dec.src1 = in_rs2;
            dec.op   = OP_SUB;
         end
         default: dec.illegal = 1'b1;
      endcase
      if (dec.rd == 5'd0) dec.we = 1'b0;
   end

   entry_t out_entry_reg, out_entry_next;
   logic   out_valid_reg, out_valid_next;
   logic   in_fire;

   assign in_fire = in_valid && in_ready;

`ifdef ALU_ISSUE_SKID_EN
   entry_t skid_entry_reg, skid_entry_next;
   logic   skid_valid_reg, skid_valid_next;

   // Skid only fills while the output is stalled, so in_ready can come straight from a flop.
   assign in_ready = !skid_valid_reg;

   always_comb begin
      out_entry_next  = out_entry_reg;
      out_valid_next  = out_valid_reg;
      skid_entry_next = skid_entry_reg;
      skid_valid_next = skid_valid_reg;
      if (flush) begin
         out_valid_next  = 1'b0;
         skid_valid_next = 1'b0;
      end else if (!out_valid_reg) begin
         if (in_fire) begin
            out_entry_next = dec;
            out_valid_next = 1'b1;
         end
      end else if (out_ready) begin
         if (skid_valid_reg) begin
            out_entry_next  = skid_entry_reg;
            skid_valid_next = 1'b0;
         end else if (in_fire) begin
            out_entry_next = dec;
         end else begin
            out_valid_next = 1'b0;
         end
      end else if (in_fire) begin
         skid_entry_next = dec;
         skid_valid_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         skid_entry_reg <= '0;
         skid_valid_reg <= 1'b0;
      end else begin
         skid_entry_reg <= skid_entry_next;
         skid_valid_reg <= skid_valid_next;
      end
   end
`else
   logic out_fire;

   assign out_fire = out_valid_reg && out_ready;
   assign in_ready = !out_valid_reg || out_ready;

   always_comb begin
      out_entry_next = out_entry_reg;
      out_valid_next = out_valid_reg;
      if (flush) begin
         out_valid_next = 1'b0;
      end else if (in_fire) begin
         out_entry_next = dec;
         out_valid_next = 1'b1;
      end else if (out_fire) begin
         out_valid_next = 1'b0;
      end
   end
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_entry_reg <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         out_entry_reg <= out_entry_next;
         out_valid_reg <= out_valid_next;
      end
   end

   assign out_valid   = out_valid_reg;
   assign alu_src0    = out_entry_reg.src0;
   assign alu_src1    = out_entry_reg.src1;
   assign alu_op      = out_entry_reg.op;
   assign out_rd      = out_entry_reg.rd;
   assign out_we      = out_entry_reg.we;
   assign out_illegal = out_entry_reg.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: randomized and directed checks of alu_issue against a queue-based reference model.
// Honours ALU_ISSUE_SKID_EN the same way as the design (two-entry capacity, registered in_ready).
module tb_alu_issue;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_inst = '0;
   logic [31:0] in_pc = '0;
   logic [31:0] in_rs1 = '0;
   logic [31:0] in_rs2 = '0;
   logic        in_ready, out_valid, out_we, out_illegal;
   logic [31:0] alu_src0, alu_src1;
   logic [4:0]  alu_op, out_rd;

   int errors = 0;
   int checks = 0;

`ifdef ALU_ISSUE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] src0;
      logic [31:0] src1;
      logic [4:0]  op;
      logic [4:0]  rd;
      logic        we;
      logic        ill;
   } ent_t;

   localparam logic [4:0] F3_OP [8] = '{5'h00, 5'h0E, 5'h04, 5'h05, 5'h0B, 5'h0F, 5'h0A, 5'h09};
   localparam logic [6:0] OPC_POOL [10] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F,
                                            7'h67, 7'h03, 7'h23, 7'h63, 7'h13};

   ent_t exp_q[$];
   int   seen_rd[$];

   always #5 clk = ~clk;

   alu_issue dut (
      .clk(clk), .rstn(rstn), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .in_rs1(in_rs1), .in_rs2(in_rs2),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_src0(alu_src0), .alu_src1(alu_src1), .alu_op(alu_op),
      .out_rd(out_rd), .out_we(out_we), .out_illegal(out_illegal)
   );

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference decode: immediates via arithmetic shifts and masks, funct3 via a lookup table.
   function automatic ent_t ref_decode(input logic [31:0] inst, input logic [31:0] pc,
                                       input logic [31:0] rs1, input logic [31:0] rs2);
      ent_t        e;
      int          f3;
      logic [31:0] imm_i, imm_s, imm_u;
      e     = '0;
      f3    = int'(inst[14:12]);
      imm_i = 32'($signed(inst) >>> 20);
      imm_s = (32'($signed(inst) >>> 25) << 5) | {27'b0, inst[11:7]};
      imm_u = inst & 32'hFFFF_F000;
      e.rd  = inst[11:7];
      case (inst[6:0])
         7'h33: begin
            e.src0 = rs1; e.src1 = rs2; e.op = F3_OP[f3]; e.we = 1'b1;
            if (f3 == 0 && inst[30]) e.op = 5'h02;
            if (f3 == 5 && inst[30]) e.op = 5'h10;
         end
         7'h13: begin
            e.src0 = rs1; e.op = F3_OP[f3]; e.we = 1'b1;
            e.src1 = (f3 == 1 || f3 == 5) ? ((inst >> 20) & 32'd31) : imm_i;
            if (f3 == 5 && inst[30]) e.op = 5'h10;
         end
         7'h37: begin e.src1 = imm_u; e.op = 5'h12; e.we = 1'b1; end
         7'h17: begin e.src0 = pc; e.src1 = imm_u; e.we = 1'b1; end
         7'h6F, 7'h67: begin e.src0 = pc; e.src1 = 32'd4; e.we = 1'b1; end
         7'h03: begin e.src0 = rs1; e.src1 = imm_i; e.we = 1'b1; end
         7'h23: begin e.src0 = rs1; e.src1 = imm_s; end
         7'h63: begin e.src0 = rs1; e.src1 = rs2; e.op = 5'h02; end
         default: e.ill = 1'b1;
      endcase
      if (e.rd == 5'd0) e.we = 1'b0;
      return e;
   endfunction

   // One clock: drive at the falling edge, check, then advance the model across the next rising edge.
   task automatic step(input logic iv, input logic [31:0] inst, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic ordy, input logic fl,
                       output logic accepted);
      ent_t        got, e;
      logic        mrdy;
      logic [31:0] pc;
      pc = $urandom & 32'hFFFF_FFFC;
      @(negedge clk);
      in_valid = iv; in_inst = inst; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2;
      out_ready = ordy; flush = fl;
      #1;
      mrdy = SKID ? (exp_q.size() < 2) : (exp_q.size() == 0 || ordy);
      check_val("in_ready", in_ready, mrdy);
      check_val("out_valid", out_valid, exp_q.size() != 0);
      got = {alu_src0, alu_src1, alu_op, out_rd, out_we, out_illegal};
      if (exp_q.size() != 0) check_val("entry", got, exp_q[0]);
      accepted = iv && mrdy && !fl;
      if (fl) begin
         exp_q.delete();
      end else begin
         if (exp_q.size() != 0 && ordy) begin
            e = exp_q.pop_front();
            seen_rd.push_back(int'(out_rd));
            $display("xfer op=%02h rd=%0d src0=%08h src1=%08h we=%0b ill=%0b",
                     alu_op, out_rd, alu_src0, alu_src1, out_we, out_illegal);
         end
         if (iv && mrdy) exp_q.push_back(ref_decode(inst, pc, rs1, rs2));
      end
   endtask

   task automatic settle;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic        acc;
      logic [31:0] r, inst;
      logic [31:0] b2b [3];
      int          idx;

      #1;
      check_val("rst_valid", out_valid, 1'b0);
      check_val("rst_ready", in_ready, 1'b1);
      check_val("rst_data", {alu_src0, alu_src1, alu_op, out_rd, out_we, out_illegal}, '0);
      #1 rstn = 1'b1;

      step(1'b1, 32'h0050_0093, 32'd0, 32'd0, 1'b1, 1'b0, acc);
      settle;
      check_val("addi_valid", out_valid, 1'b1);
      check_val("addi_op", alu_op, 5'h00);
      check_val("addi_src0", alu_src0, 32'd0);
      check_val("addi_src1", alu_src1, 32'd5);
      check_val("addi_rd", out_rd, 5'd1);
      check_val("addi_we", out_we, 1'b1);

      step(1'b1, 32'h4020_81B3, 32'd9, 32'd4, 1'b1, 1'b0, acc);
      settle;
      check_val("sub_op", alu_op, 5'h02);
      check_val("sub_src0", alu_src0, 32'd9);
      check_val("sub_src1", alu_src1, 32'd4);
      check_val("sub_rd", out_rd, 5'd3);

      step(1'b1, 32'h4030_D293, 32'h8000_0000, 32'd0, 1'b1, 1'b0, acc);
      settle;
      check_val("srai_op", alu_op, 5'h10);
      check_val("srai_src1", alu_src1, 32'd3);

      step(1'b1, 32'h1234_50B7, $urandom, $urandom, 1'b1, 1'b0, acc);
      settle;
      check_val("lui_op", alu_op, 5'h12);
      check_val("lui_src1", alu_src1, 32'h1234_5000);

      step(1'b1, 32'hFFFF_FFFF, $urandom, $urandom, 1'b1, 1'b0, acc);
      settle;
      check_val("ill_flag", out_illegal, 1'b1);
      check_val("ill_op", alu_op, 5'h00);
      check_val("ill_we", out_we, 1'b0);
      check_val("ill_srcs", {alu_src0, alu_src1}, 64'd0);
      step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, acc);
      settle;
      check_val("ill_drained", out_valid, 1'b0);

      step(1'b1, 32'h0010_0013, $urandom, $urandom, 1'b1, 1'b0, acc);
      settle;
      check_val("x0_we", out_we, 1'b0);
      step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, acc);

      // Three ADDIs to x1..x3 with a three-cycle output stall, then drain.
      b2b[0] = 32'h0010_0093; b2b[1] = 32'h0020_0113; b2b[2] = 32'h0030_0193;
      idx = 0;
      seen_rd.delete();
      for (int cyc = 0; cyc < 3; cyc++) begin
         step(idx < 3, (idx < 3) ? b2b[idx] : 32'd0, $urandom, $urandom, 1'b0, 1'b0, acc);
         if (acc) idx++;
         settle;
         if (cyc == 0) check_val("rdy_after1", in_ready, SKID);
         if (cyc == 1) check_val("rdy_after2", in_ready, 1'b0);
      end
      for (int k = 0; k < 12 && (idx < 3 || exp_q.size() != 0); k++) begin
         step(idx < 3, (idx < 3) ? b2b[idx] : 32'd0, $urandom, $urandom, 1'b1, 1'b0, acc);
         if (acc) idx++;
      end
      check_val("drain_count", seen_rd.size(), 3);
      for (int k = 0; k < 3; k++)
         check_val("drain_order", (k < seen_rd.size()) ? seen_rd[k] : -1, k + 1);

      step(1'b1, 32'h0050_0293, $urandom, $urandom, 1'b0, 1'b0, acc);
      step(1'b1, 32'h0060_0313, $urandom, $urandom, 1'b0, 1'b1, acc);
      settle;
      check_val("flush_valid", out_valid, 1'b0);

      step(1'b1, 32'h0070_0393, $urandom, $urandom, 1'b0, 1'b0, acc);
      settle;
      check_val("pre_rst_valid", out_valid, 1'b1);
      in_valid = 1'b0;
      #2 rstn = 1'b0;
      #1;
      check_val("async_rst_valid", out_valid, 1'b0);
      check_val("async_rst_data", {alu_src0, alu_src1, alu_op, out_rd, out_we, out_illegal}, '0);
      check_val("async_rst_ready", in_ready, 1'b1);
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;

      for (int n = 0; n < 400; n++) begin
         r    = $urandom;
         inst = ($urandom_range(0, 9) == 0) ? r : {r[31:7], OPC_POOL[$urandom_range(0, 9)]};
         step($urandom_range(0, 9) < 7, inst, $urandom, $urandom,
              $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, acc);
      end
      repeat (3) step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, acc);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
